ext_intf_transmitter: RTL and testbench
=======================================

# ext_intf_transmitter

Initiator-side bridge for the external-interface link. It accepts single-word SCx bus requests from an on-chip master and serialises each one into 16-bit request beats on Ext_TRANS_*. It then collects the 8-bit response beats from Ext_RESP_* and completes the SCx access with read data, a fault flag or a timeout. It sits between a core-side SCx master and the chip pins, opposite the board-side receiver/SRAM.

## Interface
Parameters:
- TIMEOUT, 16: cycles allowed without a beat transfer before the access is aborted; 0 disables the timeout; maximum 65535.

Ports:
- CLK  in  1  single clock; all logic, including the external link, is synchronous to its rising edge.
- RST  in  1  reset, synchronous, active-high.
- SCx_REQ  in  1  access request; the master holds it until SCx_nWAIT is high.
- SCx_WT  in  1  1 = write, 0 = read.
- SCx_BE  in  4  byte enables.
- SCx_ADDR  in  32  byte address.
- SCx_WDT  in  32  write data.
- SCx_nWAIT  out  1  low while an access is in progress.
- SCx_FAULT  out  1  far end returned an error response.
- SCx_TimeOut  out  1  access aborted by the timeout.
- SCx_RDT  out  32  read data.
- Ext_TRANS_VALID  out  1  request beat valid.
- Ext_TRANS_DATA  out  16  request beat payload.
- Ext_TRANS_ACK  in  1  far end accepts the request beat.
- Ext_RESP_VALID  in  1  response beat valid.
- Ext_RESP_RESP  in  1  1 = error on this beat.
- Ext_RESP_DATA  in  8  response beat payload.
- Ext_RESP_ACK  out  1  this block accepts the response beat.

## Operation
- FSM states: IDLE, HDR, ADDR_H, ADDR_L, WDT_H, WDT_L, RESP, DONE.
- IDLE with SCx_REQ=1: capture WT, BE, ADDR and WDT into internal registers, then go to HDR.
- Request beats, sent in state order:
  - HDR = {WT, 11'b0, BE}
  - ADDR_H = ADDR[31:16]
  - ADDR_L = ADDR[15:0]
  - Writes only: WDT_H = WDT[31:16], then WDT_L = WDT[15:0].
- Request beat handshake:
  - Ext_TRANS_VALID and Ext_TRANS_DATA are registered and stay stable until the cycle in which VALID and ACK are both 1. That cycle is the transfer.
  - After a transfer the FSM advances. VALID stays high across back-to-back beats.
- After the last request beat (ADDR_L for a read, WDT_L for a write), go to RESP.
- Response beats:
  - Ext_RESP_ACK is registered and is 1 in RESP only. A beat transfers when VALID and ACK are both 1.
  - A read expects 4 beats carrying RDT MSB-first: [31:24], [23:16], [15:8], [7:0].
  - A write expects 1 beat; its data is ignored.
  - A 2-bit beat counter tracks response beats.
  - Ext_RESP_RESP=1 on any beat sets a sticky fault for the current access.
- After the final response beat, go to DONE. DONE returns to IDLE unconditionally on the next cycle.
- Entering DONE loads the SCx result registers:
  - SCx_RDT = assembled data (0 for a write or on timeout).
  - SCx_FAULT = sticky fault.
  - SCx_TimeOut = timeout flag.
  - These registers hold until the next entry to DONE.
- SCx_nWAIT = (state==IDLE && !SCx_REQ) || state==DONE. It is combinational, so it drops in the same cycle that the request is first seen.
- Timeout:
  - A 16-bit counter is cleared on IDLE exit and on every request or response beat transfer.
  - It increments every cycle spent in HDR..RESP.
  - When it reaches TIMEOUT (with TIMEOUT≠0), the block goes to DONE with SCx_TimeOut=1, FAULT=0, RDT=0, and drops Ext_TRANS_VALID and Ext_RESP_ACK.
- Ext_RESP_VALID seen outside RESP is not acknowledged and is ignored.

## Timing
- Reset values:
  - State IDLE.
  - Ext_TRANS_VALID=0, Ext_TRANS_DATA=0, Ext_RESP_ACK=0.
  - SCx_FAULT=0, SCx_TimeOut=0, SCx_RDT=0.
  - Counters 0.
  - SCx_nWAIT follows the IDLE equation, so it equals !SCx_REQ.
- RST asserted mid-access: IDLE at the next edge; VALID and ACK drop; no abort is signalled on the link.
- Minimum latency, with far-end ACK and VALID held high and REQ sampled at cycle 0:
  - Read: request beats transfer at cycles 1–3, response beats at cycles 4–7, DONE (nWAIT=1) at cycle 8.
  - Write: request beats at cycles 1–5, response beat at cycle 6, DONE at cycle 7.
- A new REQ is accepted at the earliest one cycle after DONE, from IDLE.
- A timeout fires after exactly TIMEOUT consecutive stalled cycles. DONE is entered on the following edge.

## Test plan
- Read, ADDR=0x0000_0104, BE=0xF, far end always ready, response bytes 0x12, 0x34, 0x56, 0x78:
  - Request beats are 0x000F, 0x0000, 0x0104.
  - SCx_RDT=0x12345678, FAULT=0, and nWAIT is high exactly 8 cycles after REQ.
- Write, ADDR=0x8000_0010, BE=0x3, WDT=0xDEAD_BEEF:
  - Request beats are 0x8003, 0x8000, 0x0010, 0xDEAD, 0xBEEF, followed by one response beat.
  - nWAIT is high at cycle 7.
- Random Ext_TRANS_ACK/Ext_RESP_VALID stalls (0–5 cycles) on 100 mixed accesses: DATA is stable whenever VALID=1 and ACK=0; every result matches the model.
- Read where the third response beat has RESP=1: SCx_FAULT=1 in DONE, and all 4 beats are still consumed.
- TIMEOUT=16, far end never asserts Ext_RESP_VALID: SCx_TimeOut=1 and RDT=0 in DONE, and Ext_RESP_ACK=0 afterwards. Then a clean read succeeds with TimeOut=0.
- RST pulsed while in ADDR_L: the next cycle shows IDLE with VALID=0; a subsequent read completes correctly.

Source files
------------

// File: rtl/ext_intf_transmitter.sv
// ext_intf_transmitter: initiator-side bridge from a single-word SCx master to
// the external link. Each access is serialised into 16-bit request beats
// (header, address high/low, and for writes data high/low). The block then
// collects 8-bit response beats and completes the access with read data, a
// fault flag or a timeout.
//
// Handshake rule shared by both link directions: a beat moves in the cycle
// where the sender's VALID and the receiver's ACK are both 1. A sender holds
// VALID and its payload stable until that cycle.
module ext_intf_transmitter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCx_REQ,
    input  logic        SCx_WT,
    input  logic [3:0]  SCx_BE,
    input  logic [31:0] SCx_ADDR,
    input  logic [31:0] SCx_WDT,
    output logic        SCx_nWAIT,
    output logic        SCx_FAULT,
    output logic        SCx_TimeOut,
    output logic [31:0] SCx_RDT,
    output logic        Ext_TRANS_VALID,
    output logic [15:0] Ext_TRANS_DATA,
    input  logic        Ext_TRANS_ACK,
    input  logic        Ext_RESP_VALID,
    input  logic        Ext_RESP_RESP,
    input  logic [7:0]  Ext_RESP_DATA,
    output logic        Ext_RESP_ACK
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        ADDR_H = 3'd2,
        ADDR_L = 3'd3,
        WDT_H  = 3'd4,
        WDT_L  = 3'd5,
        RESP   = 3'd6,
        DONE   = 3'd7
    } state_t;

    // Stall limit as a counter value; only meaningful when TIMEOUT != 0.
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_t      state_q, state_d;

    // Captured access
    logic        cap_wt_q, cap_wt_d;
    logic [3:0]  cap_be_q, cap_be_d;
    logic [31:0] cap_addr_q, cap_addr_d;
    logic [31:0] cap_wdt_q, cap_wdt_d;

    // Registered link outputs
    logic        trans_valid_q, trans_valid_d;
    logic [15:0] trans_data_q, trans_data_d;
    logic        resp_ack_q, resp_ack_d;

    // Response collection
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] acc_q, acc_d;

    // Stall counter
    logic [15:0] to_cnt_q, to_cnt_d;

    // SCx result registers, loaded on entry to DONE
    logic        res_fault_q, res_fault_d;
    logic        res_to_q, res_to_d;
    logic [31:0] res_rdt_q, res_rdt_d;

    logic        trans_xfer;
    logic        resp_xfer;
    logic        busy;
    logic        to_hit;

    assign trans_xfer = trans_valid_q & Ext_TRANS_ACK;
    assign resp_xfer  = resp_ack_q & Ext_RESP_VALID;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    // The counter only gets this far after TIMEOUT consecutive stalled cycles,
    // because every beat transfer clears it.
    assign to_hit     = (TIMEOUT != 0) && busy && (to_cnt_q == TO_LIM);

    // Next-state, capture, response assembly, timeout and link-output logic
    always_comb begin
        state_d     = state_q;
        cap_wt_d    = cap_wt_q;
        cap_be_d    = cap_be_q;
        cap_addr_d  = cap_addr_q;
        cap_wdt_d   = cap_wdt_q;
        beat_cnt_d  = beat_cnt_q;
        fault_d     = fault_q;
        acc_d       = acc_q;
        to_cnt_d    = to_cnt_q;
        res_fault_d = res_fault_q;
        res_to_d    = res_to_q;
        res_rdt_d   = res_rdt_q;

        case (state_q)
            IDLE: begin
                if (SCx_REQ) begin
                    cap_wt_d   = SCx_WT;
                    cap_be_d   = SCx_BE;
                    cap_addr_d = SCx_ADDR;
                    cap_wdt_d  = SCx_WDT;
                    beat_cnt_d = 2'd0;
                    fault_d    = 1'b0;
                    acc_d      = 32'h0;
                    to_cnt_d   = 16'h0;
                    state_d    = HDR;
                end
            end
            HDR:    if (trans_xfer) state_d = ADDR_H;
            ADDR_H: if (trans_xfer) state_d = ADDR_L;
            ADDR_L: if (trans_xfer) state_d = cap_wt_q ? WDT_H : RESP;
            WDT_H:  if (trans_xfer) state_d = WDT_L;
            WDT_L:  if (trans_xfer) state_d = RESP;
            RESP: begin
                if (resp_xfer) begin
                    fault_d    = fault_q | Ext_RESP_RESP;
                    acc_d      = {acc_q[23:0], Ext_RESP_DATA};
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    // Writes finish on their single beat, reads on the fourth.
                    if (cap_wt_q || (beat_cnt_q == 2'd3)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Stall counting while the access is on the link.
        if (busy) begin
            to_cnt_d = (trans_xfer || resp_xfer) ? 16'h0 : to_cnt_q + 16'd1;
        end

        // An expired stall budget aborts the access regardless of progress.
        if (to_hit) begin
            state_d = DONE;
        end

        // Results are latched once, on the way into DONE.
        if ((state_d == DONE) && (state_q != DONE)) begin
            if (to_hit) begin
                res_to_d    = 1'b1;
                res_fault_d = 1'b0;
                res_rdt_d   = 32'h0;
            end else begin
                res_to_d    = 1'b0;
                res_fault_d = fault_d;
                res_rdt_d   = cap_wt_q ? 32'h0 : acc_d;
            end
        end

        // Link outputs are registered, so they are derived from the next state.
        trans_valid_d = state_d inside {HDR, ADDR_H, ADDR_L, WDT_H, WDT_L};
        resp_ack_d    = (state_d == RESP);
        case (state_d)
            HDR:     trans_data_d = {cap_wt_d, 11'b0, cap_be_d};
            ADDR_H:  trans_data_d = cap_addr_d[31:16];
            ADDR_L:  trans_data_d = cap_addr_d[15:0];
            WDT_H:   trans_data_d = cap_wdt_d[31:16];
            WDT_L:   trans_data_d = cap_wdt_d[15:0];
            default: trans_data_d = trans_data_q;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            cap_wt_q      <= 1'b0;
            cap_be_q      <= 4'h0;
            cap_addr_q    <= 32'h0;
            cap_wdt_q     <= 32'h0;
            trans_valid_q <= 1'b0;
            trans_data_q  <= 16'h0;
            resp_ack_q    <= 1'b0;
            beat_cnt_q    <= 2'd0;
            fault_q       <= 1'b0;
            acc_q         <= 32'h0;
            to_cnt_q      <= 16'h0;
            res_fault_q   <= 1'b0;
            res_to_q      <= 1'b0;
            res_rdt_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            cap_wt_q      <= cap_wt_d;
            cap_be_q      <= cap_be_d;
            cap_addr_q    <= cap_addr_d;
            cap_wdt_q     <= cap_wdt_d;
            trans_valid_q <= trans_valid_d;
            trans_data_q  <= trans_data_d;
            resp_ack_q    <= resp_ack_d;
            beat_cnt_q    <= beat_cnt_d;
            fault_q       <= fault_d;
            acc_q         <= acc_d;
            to_cnt_q      <= to_cnt_d;
            res_fault_q   <= res_fault_d;
            res_to_q      <= res_to_d;
            res_rdt_q     <= res_rdt_d;
        end
    end

    // nWAIT is combinational so it drops in the cycle the request first appears.
    assign SCx_nWAIT       = ((state_q == IDLE) && !SCx_REQ) || (state_q == DONE);
    assign SCx_FAULT       = res_fault_q;
    assign SCx_TimeOut     = res_to_q;
    assign SCx_RDT         = res_rdt_q;
    assign Ext_TRANS_VALID = trans_valid_q;
    assign Ext_TRANS_DATA  = trans_data_q;
    assign Ext_RESP_ACK    = resp_ack_q;

endmodule

// File: tb/tb_ext_intf_transmitter.sv
// Bench for ext_intf_transmitter: an SCx master driver, a far-end link model
// with optional random stalls, and a scoreboard fed from a reference model.
module tb_ext_intf_transmitter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        scx_req, scx_wt;
  logic [3:0]  scx_be;
  logic [31:0] scx_addr, scx_wdt;
  logic        scx_nwait, scx_fault, scx_timeout;
  logic [31:0] scx_rdt;
  logic        ext_trans_valid;
  logic [15:0] ext_trans_data;
  logic        ext_trans_ack;
  logic        ext_resp_valid, ext_resp_resp;
  logic [7:0]  ext_resp_data;
  logic        ext_resp_ack;

  ext_intf_transmitter #(.TIMEOUT(16)) dut (
    .CLK             (clk),
    .RST             (rst),
    .SCx_REQ         (scx_req),
    .SCx_WT          (scx_wt),
    .SCx_BE          (scx_be),
    .SCx_ADDR        (scx_addr),
    .SCx_WDT         (scx_wdt),
    .SCx_nWAIT       (scx_nwait),
    .SCx_FAULT       (scx_fault),
    .SCx_TimeOut     (scx_timeout),
    .SCx_RDT         (scx_rdt),
    .Ext_TRANS_VALID (ext_trans_valid),
    .Ext_TRANS_DATA  (ext_trans_data),
    .Ext_TRANS_ACK   (ext_trans_ack),
    .Ext_RESP_VALID  (ext_resp_valid),
    .Ext_RESP_RESP   (ext_resp_resp),
    .Ext_RESP_DATA   (ext_resp_data),
    .Ext_RESP_ACK    (ext_resp_ack)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];    // {timeout, fault, rdt} per access
  logic [15:0] beat_q[$];   // request beats the far end must see, in order
  logic [8:0]  resp_q[$];   // {resp, data} beats the far end will return
  bit          stall_en = 1'b0;
  int          trans_stall = 0;
  int          resp_stall = 0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_data = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // ---------------- far-end driver ----------------
  always @(posedge clk) begin
    #1;
    if (trans_stall > 0) begin
      ext_trans_ack = 1'b0;
      trans_stall--;
    end else begin
      ext_trans_ack = 1'b1;
    end
    if (resp_q.size() > 0 && resp_stall == 0) begin
      ext_resp_valid = 1'b1;
      ext_resp_resp  = resp_q[0][8];
      ext_resp_data  = resp_q[0][7:0];
    end else begin
      if (resp_stall > 0) resp_stall--;
      ext_resp_valid = 1'b0;
      ext_resp_resp  = 1'b0;
      ext_resp_data  = 8'($urandom);
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (prev_hold && !rst) begin
      check("trans_hold_valid", 64'(ext_trans_valid), 64'(1));
      check("trans_hold_data", 64'(ext_trans_data), 64'(prev_data));
    end
    prev_hold = (ext_trans_valid === 1'b1) && (ext_trans_ack === 1'b0) && !rst;
    prev_data = ext_trans_data;

    if (ext_trans_valid === 1'b1 && ext_trans_ack === 1'b1) begin
      if (beat_q.size() == 0) fail("unexpected_req_beat", 64'(ext_trans_data));
      else check("req_beat", 64'(ext_trans_data), 64'(beat_q.pop_front()));
      if (stall_en) trans_stall = $urandom_range(0, 5);
    end

    if (ext_resp_valid === 1'b1 && ext_resp_ack === 1'b1) begin
      if (resp_q.size() > 0) void'(resp_q.pop_front());
      else fail("unexpected_resp_ack", 64'(ext_resp_data));
      if (stall_en) resp_stall = $urandom_range(0, 5);
    end

    if (scx_req === 1'b1 && scx_nwait === 1'b1) begin
      if (exp_q.size() == 0) fail("unexpected_done", 64'({scx_timeout, scx_fault, scx_rdt}));
      else check("result", 64'({scx_timeout, scx_fault, scx_rdt}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- master driver ----------------
  // rerr[i] marks an error on response beat i (beat 0 first). Returns the
  // number of cycles from the request cycle to the cycle nWAIT is high.
  task automatic do_access(input bit wt, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdt, input logic [31:0] rbytes,
                           input logic [3:0] rerr, input bit expect_to, output int cyc);
    logic [33:0] exp;
    beat_q.push_back({wt, 11'b0, be});
    beat_q.push_back(addr[31:16]);
    beat_q.push_back(addr[15:0]);
    if (wt) begin
      beat_q.push_back(wdt[31:16]);
      beat_q.push_back(wdt[15:0]);
    end
    if (expect_to) begin
      exp = {1'b1, 1'b0, 32'h0};
    end else if (wt) begin
      resp_q.push_back({rerr[0], rbytes[7:0]});
      exp = {1'b0, rerr[0], 32'h0};
    end else begin
      for (int i = 0; i < 4; i++) resp_q.push_back({rerr[i], rbytes[31-8*i -: 8]});
      exp = {1'b0, |rerr, rbytes};
    end
    exp_q.push_back(exp);

    @(posedge clk);
    #1;
    scx_req  = 1'b1;
    scx_wt   = wt;
    scx_be   = be;
    scx_addr = addr;
    scx_wdt  = wdt;
    #1;
    check("nwait_drop", 64'(scx_nwait), 64'(0));
    cyc = 0;
    @(negedge clk);
    while (scx_nwait !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (scx_nwait !== 1'b1) fail("access_hang", 64'(cyc));
    @(posedge clk);
    #1;
    scx_req  = 1'b0;
    scx_wt   = 1'($urandom);
    scx_addr = $urandom;
    scx_wdt  = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    logic [3:0] rerr;
    rst = 1'b1;
    scx_req = 1'b0; scx_wt = 1'b0; scx_be = 4'h0; scx_addr = 32'h0; scx_wdt = 32'h0;
    ext_trans_ack = 1'b1; ext_resp_valid = 1'b0; ext_resp_resp = 1'b0; ext_resp_data = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trans_valid", 64'(ext_trans_valid), 64'(0));
    check("rst_trans_data", 64'(ext_trans_data), 64'(0));
    check("rst_resp_ack", 64'(ext_resp_ack), 64'(0));
    check("rst_result", 64'({scx_timeout, scx_fault, scx_rdt}), 64'(0));
    check("rst_nwait", 64'(scx_nwait), 64'(1));
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed read at minimum latency.
    do_access(1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h1234_5678, 4'b0000, 1'b0, cyc);
    check("read_latency", 64'(cyc), 64'(8));

    // Directed write at minimum latency.
    do_access(1'b1, 4'h3, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_00A5, 4'b0000, 1'b0, cyc);
    check("write_latency", 64'(cyc), 64'(7));

    // Read with an error on the third response beat; all four beats drain.
    do_access(1'b0, 4'hC, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 4'b0100, 1'b0, cyc);
    check("fault_read_latency", 64'(cyc), 64'(8));
    check("fault_resp_drained", 64'(resp_q.size()), 64'(0));

    // Far end never answers: access times out.
    do_access(1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h0, 4'b0000, 1'b1, cyc);
    n_cmp++;
    if (cyc < 20 || cyc > 21) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles, expected 20..21", cyc);
    end
    @(negedge clk);
    check("timeout_resp_ack_after", 64'(ext_resp_ack), 64'(0));
    check("timeout_trans_valid_after", 64'(ext_trans_valid), 64'(0));

    // Clean read after the timeout.
    do_access(1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'hA5A5_0F0F, 4'b0000, 1'b0, cyc);
    check("post_timeout_latency", 64'(cyc), 64'(8));

    // Reset pulsed while the address-low beat is on the link.
    beat_q.push_back({1'b0, 11'b0, 4'hF});
    beat_q.push_back(16'h0000);
    beat_q.push_back(16'h0500);
    @(posedge clk);
    #1;
    scx_req = 1'b1; scx_wt = 1'b0; scx_be = 4'hF; scx_addr = 32'h0000_0500;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_addr_l_data", 64'(ext_trans_data), 64'(16'h0500));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    scx_req = 1'b0;
    @(negedge clk);
    check("rst_mid_trans_valid", 64'(ext_trans_valid), 64'(0));
    check("rst_mid_resp_ack", 64'(ext_resp_ack), 64'(0));
    check("rst_mid_nwait", 64'(scx_nwait), 64'(1));
    beat_q.delete();

    do_access(1'b0, 4'h6, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 4'b0000, 1'b0, cyc);
    check("post_reset_latency", 64'(cyc), 64'(8));

    // Random mixed traffic with link stalls.
    stall_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      for (int b = 0; b < 4; b++) rerr[b] = ($urandom_range(0, 7) == 0);
      do_access(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, rerr, 1'b0, cyc);
    end
    stall_en = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("end_exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("end_beat_q_empty", 64'(beat_q.size()), 64'(0));
    check("end_resp_q_empty", 64'(resp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
